// File: rtl/core_pkg.sv
// Shared core definitions: instruction encodings, opcode constants and the
// fetch-stage state type.
package core_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from execute
// and the decode hand-off.
interface instr_fetch_unit_if;

    // Valid/ready: a transfer happens on a rising edge where valid && ready are
    // both high; the producer may withdraw valid before the handshake, and the
    // response channel and redirect carry no backpressure (valid-only).
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO with flush; head entry is read straight from storage.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Upstream credit gating must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, credit-gated in-order fetch, instruction
// buffer towards decode, and redirect flush with drain of in-flight responses.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus,
    output fetch_state_e        state_o
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_after_rsp;
    logic [CW:0]   credit_used;
    logic [63:0]   head;
    logic [31:0]   tag_pc;
    logic          req_valid;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          id_valid;
    logic [31:0]   id_instr;

    assign id_valid = (count != '0);
    assign pop      = id_valid && bus.id_ready;

    // A head entry leaving this cycle frees its slot for a new request.
    assign credit_used = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
    assign req_valid   = !rst && (state_q == RUN) && !bus.redirect_valid &&
                         (credit_used < (CW+1)'(DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign push        = bus.imem_rsp_valid && (state_q == RUN) && !bus.redirect_valid;
    assign out_after_rsp = outstanding - CW'(bus.imem_rsp_valid);

    // Tag queue tracks every accepted address until its response returns,
    // including responses that will be dropped, so its fill is the outstanding count.
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (bus.imem_rsp_valid),
        .data_o  (tag_pc),
        .count_o (outstanding)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.redirect_valid),
        .push_i  (push),
        .data_i  ({tag_pc, bus.imem_rsp_data}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        if (req_fire) pc_d = pc_q + 32'd4;
        if (bus.redirect_valid) pc_d = word_align(bus.redirect_pc);
        case (state_q)
            RUN: begin
                if (bus.redirect_valid && out_after_rsp != '0) begin
                    state_d   = DRAIN;
                    discard_d = out_after_rsp;
                end
            end
            DRAIN: begin
                if (bus.imem_rsp_valid) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    assign id_instr           = id_valid ? head[31:0] : NOP_INSTR;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_instr       = id_instr;
    assign bus.id_pc          = id_valid ? head[63:32] : 32'h0;
    assign bus.id_opcode      = id_instr[6:0];
    assign state_o            = state_q;

endmodule
